// File: rtl/fc_result_packer_pkg.sv
// Shared constants and types for the FC result packer and its neighbours.
// The argmax stage imports the same DW/NUM_CLASS constants so both ends of
// the packed vector agree on its layout.
package fc_result_packer_pkg;

  localparam int FC_DW        = 32;  // width of one neuron result (signed)
  localparam int FC_NUM_CLASS = 3;   // words per packed vector
  localparam int FC_MIN_GAP   = 4;   // minimum cycles between publish pulses

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } fc_state_e;

endpackage

// File: rtl/fc_result_packer_min_gap_timer.sv
// min_gap_timer: enforces a minimum spacing between events.
// A load reloads the counter to MIN_GAP-1; it then counts down to 0 and
// saturates there. o_busy is high while the counter is nonzero, so an event
// loaded at cycle t lets the next event be issued no earlier than t+MIN_GAP.
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  asynchronous active-low reset (counter cleared)
//   i_load  in  reload the counter (an event is being issued)
//   o_busy  out counter nonzero; a new event must wait
module min_gap_timer #(
  parameter int MIN_GAP = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_busy
);

  localparam int            CW     = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(MIN_GAP - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= RELOAD;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_busy = (r_count != '0);

endmodule

// File: rtl/fc_result_packer.sv
// fc_result_packer: serial-to-parallel packer for the FC layer output.
// Collects NUM_CLASS signed words from a valid/ready stream (word k lands in
// lane k) and publishes them as one vector with a one-cycle m_valid pulse.
// Consecutive pulses are at least MIN_GAP cycles apart; a finished vector
// that arrives too early waits in HOLD with s_ready low. A vector whose
// s_last does not coincide with the NUM_CLASS-th word is dropped and
// reported with a one-cycle frame_err pulse.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   s_data      serial neuron result (DW bits, stored raw)
//   s_valid     s_data valid
//   s_last      final word of a vector, qualified by s_valid
//   s_ready     packer can accept a word (combinational, high in COLLECT)
//   m_data      packed vector, word k at [k*DW +: DW]; changes only on publish
//   m_valid     one-cycle publish pulse
//   frame_err   one-cycle framing-violation pulse
module fc_result_packer
  import fc_result_packer_pkg::*;
#(
  parameter int DW        = FC_DW,
  parameter int NUM_CLASS = FC_NUM_CLASS,
  parameter int MIN_GAP   = FC_MIN_GAP
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DW-1:0]           s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [NUM_CLASS*DW-1:0] m_data,
  output logic                    m_valid,
  output logic                    frame_err
);

  localparam int               CNT_W   = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_CLASS - 1);

  fc_state_e               r_state;
  fc_state_e               w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [DW-1:0]           r_lane [NUM_CLASS];
  logic [NUM_CLASS*DW-1:0] r_m_data;
  logic [NUM_CLASS*DW-1:0] w_pub_vec;
  logic                    r_m_valid;
  logic                    r_frame_err;
  logic                    w_accept;
  logic                    w_publish;
  logic                    w_frame_err_nxt;
  logic                    w_gap_busy;

  assign s_ready   = (r_state == ST_COLLECT);
  assign w_accept  = s_valid && s_ready;
  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign frame_err = r_frame_err;

  min_gap_timer #(.MIN_GAP(MIN_GAP)) u_gap (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_publish),
    .o_busy (w_gap_busy)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_publish       = 1'b0;
    w_frame_err_nxt = 1'b0;
    unique case (r_state)
      ST_COLLECT: begin
        if (w_accept) begin
          if (r_cnt != CNT_MAX) begin
            if (s_last) begin
              w_frame_err_nxt = 1'b1;
              w_cnt_nxt       = '0;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end else if (!s_last) begin
            w_frame_err_nxt = 1'b1;
            w_cnt_nxt       = '0;
          end else begin
            w_cnt_nxt = '0;
            if (w_gap_busy) w_state_nxt = ST_HOLD;
            else            w_publish   = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!w_gap_busy) begin
          w_publish   = 1'b1;
          w_state_nxt = ST_COLLECT;
        end
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  // Publishing straight from COLLECT happens on the edge that accepts the last
  // word, so that word is taken from s_data rather than from its lane.
  always_comb begin
    w_pub_vec = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      w_pub_vec[k*DW +: DW] = (r_state == ST_COLLECT && k == NUM_CLASS - 1)
                              ? s_data : r_lane[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_COLLECT;
      r_cnt       <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_m_valid   <= w_publish;
      r_frame_err <= w_frame_err_nxt;
      if (w_publish) r_m_data <= w_pub_vec;
    end
  end

  // NOTE: the collect lanes are deliberately not reset: each lane is written
  // in the current vector before it can be published, so reset only costs
  // routing here.
  always_ff @(posedge clk) begin
    if (w_accept) r_lane[r_cnt] <= s_data;
  end

endmodule

// File: tb/tb_fc_result_packer.sv
// Bench for fc_result_packer (DW=32, NUM_CLASS=3, MIN_GAP=4).
// A vector-level model predicts, per cycle, m_valid, frame_err, m_data and
// s_ready: a good vector published at max(last word cycle + 1, previous
// pulse + MIN_GAP), with s_ready low while one is waiting. Directed tests pin
// the model with hand-computed literals.
module tb_fc_result_packer;

  localparam int DW = 32;
  localparam int NC = 3;
  localparam int MG = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DW-1:0]    s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic [NC*DW-1:0] m_data;
  logic             m_valid;
  logic             frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  fc_result_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  logic [DW-1:0]    words[$];
  logic [NC*DW-1:0] exp_md = '0;
  logic [NC*DW-1:0] pend_vec;
  logic [NC*DW-1:0] last_data = '0;
  bit               have_pend = 0;
  bit               fe_flag = 0;
  int               pend_cyc = 0;
  int               model_last = -100;
  int               dut_last = -1;
  int               pulse_cnt = 0;
  int               fe_cnt = 0;

  always @(negedge clk) begin
    bit exp_mv, exp_rdy, exp_fe;
    if (!rst_n) begin
      words.delete();
      have_pend  = 0;
      fe_flag    = 0;
      exp_md     = '0;
      model_last = -100;
      dut_last   = -1;
    end else begin
      exp_mv = have_pend && (pend_cyc == cyc);
      if (exp_mv) begin
        exp_md     = pend_vec;
        have_pend  = 0;
        model_last = cyc;
      end
      exp_rdy = !have_pend;
      exp_fe  = fe_flag;
      fe_flag = 0;
      check("m_valid", m_valid, exp_mv);
      check("frame_err", frame_err, exp_fe);
      check("m_data", m_data, exp_md);
      check("s_ready", s_ready, exp_rdy);
      if (m_valid) begin
        if (dut_last >= 0) check("pulse_gap_ge_min", (cyc - dut_last) >= MG, 1);
        dut_last  = cyc;
        last_data = m_data;
        pulse_cnt++;
      end
      if (frame_err) fe_cnt++;
      if (s_valid && exp_rdy) begin
        words.push_back(s_data);
        if (s_last || words.size() == NC) begin
          if (s_last && words.size() == NC) begin
            pend_vec  = {words[2], words[1], words[0]};
            have_pend = 1;
            pend_cyc  = (cyc + 1 > model_last + MG) ? cyc + 1 : model_last + MG;
          end else begin
            fe_flag = 1;
          end
          words.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [DW-1:0] d, input logic l, output int acc_cyc);
    bit acc;
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    acc     = 0;
    n       = 0;
    acc_cyc = -1;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc     = s_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_vec(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic [DW-1:0] w2, output int c0);
    int c;
    drive(w0, 1'b0, c0);
    drive(w1, 1'b0, c);
    drive(w2, 1'b1, c);
  endtask

  initial begin
    int c0, c;
    // 1 reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;

    // 2 single vector: m_valid three cycles after the first word
    send_vec(32'h0000_0005, 32'hFFFF_FFF0, 32'h0000_0009, c0);
    idle(3);
    check("single_pulses", pulse_cnt, 1);
    check("single_data", last_data, 96'h00000009_FFFFFFF0_00000005);
    check("single_latency", dut_last - c0, 3);

    // 3 streaming: pulses at +3, +7, +11, +15 from the first accept
    idle(6);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) send_vec(32'h30 - 32'h30, 32'h01, 32'h02, c0);
      else        send_vec(32'(i * 16), 32'(i * 16 + 1), 32'(i * 16 + 2), c);
    end
    idle(4);
    check("stream_pulses", pulse_cnt, 5);
    check("stream_span", dut_last - c0, 15);
    check("stream_data", last_data, 96'h00000032_00000031_00000030);

    // 4 early last: error, previous m_data held, then a clean vector
    drive(32'h0000_AAAA, 1'b0, c);
    drive(32'h0000_BBBB, 1'b1, c);
    idle(2);
    check("early_fe", fe_cnt, 1);
    check("early_no_pulse", pulse_cnt, 5);
    check("early_hold", m_data, 96'h00000032_00000031_00000030);
    send_vec(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, c);
    idle(3);
    check("early_next_data", last_data, 96'h00000001_80000000_7FFFFFFF);

    // 5 missing last: error, no pulse, counter back at lane 0
    drive(32'h11, 1'b0, c);
    drive(32'h22, 1'b0, c);
    drive(32'h33, 1'b0, c);
    idle(2);
    check("miss_fe", fe_cnt, 2);
    check("miss_no_pulse", pulse_cnt, 6);
    send_vec(32'h4, 32'h5, 32'h6, c);
    idle(3);
    check("miss_next_data", last_data, 96'h00000006_00000005_00000004);

    // 6 reset mid-vector
    drive(32'hDEAD, 1'b0, c);
    drive(32'hBEEF, 1'b0, c);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_m_data", m_data, 0);
    @(posedge clk);
    #1;
    send_vec(32'hA, 32'hB, 32'hC, c);
    idle(3);
    check("midrst_pulses", pulse_cnt, 8);
    check("midrst_data", last_data, 96'h0000000C_0000000B_0000000A);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
